clock12_timekeeper: RTL

CLOCK12_TIMEKEEPER -- requirements
Module: clock12_timekeeper

---
 rtl/clock12_pkg.sv | 20 ++
 rtl/clock12_prescaler.sv | 32 +++
 rtl/clock12_timekeeper.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clock12_pkg.sv
// Shared constants, load-FSM state type and load-legality helper for the 12-hour timekeeper.
package clock12_pkg;

  localparam logic [5:0] SEC_MAX     = 6'd59;
  localparam logic [5:0] MIN_MAX     = 6'd59;
  localparam logic [3:0] HOUR_MAX    = 4'd12;
  localparam logic [3:0] HOUR_MIN    = 4'd1;
  // Advancing out of this hour crosses noon/midnight and flips the meridiem.
  localparam logic [3:0] HOUR_PRE_12 = 4'd11;

  typedef enum logic {
    StIdle  = 1'b0,
    StApply = 1'b1
  } load_state_e;

  function automatic logic load_legal(input logic [3:0] hour_v, input logic [5:0] min_v);
    return (hour_v >= HOUR_MIN) && (hour_v <= HOUR_MAX) && (min_v <= MIN_MAX);
  endfunction

endpackage

// File: rtl/clock12_prescaler.sv
// Divides accepted tick pulses down to a once-per-second wrap strobe; synchronous clear.
module clock12_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic wrap_o
);

  localparam int unsigned CntW = $clog2(TICKS_PER_SEC);
  localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Combinational so the seconds counter advances in the same edge as the wrap.
  assign wrap_o = tick_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock12_timekeeper.sv
// 12-hour hh:mm:ss AM/PM timekeeper with a two-state load FSM.
// Optional alarm comparator is compiled in when ALARM_EN is defined.
module clock12_timekeeper
  import clock12_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [3:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       set_pm,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [3:0] hour,
  output logic       pm,
  output logic       sec_pulse,
  output logic       set_err
`ifdef ALARM_EN
  ,
  input  logic [3:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_pm,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm
`endif
);

  load_state_e state_q, state_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [3:0]  hour_q, hour_d;
  logic        pm_q, pm_d;
  logic        sec_pulse_q, sec_pulse_d;
  logic        set_err_q, set_err_d;
  logic        set_ready_q, set_ready_d;

  logic idle, load_req, accept, reject;
  logic presc_tick, presc_clr, wrap, incr;

  assign idle     = (state_q == StIdle);
  assign load_req = idle && set_valid;
  assign accept   = load_req && load_legal(set_hour, set_min);
  assign reject   = load_req && !load_legal(set_hour, set_min);

  // A same-cycle load discards the tick; APPLY ignores ticks entirely.
  assign presc_tick = tick && idle && !accept;
  assign presc_clr  = reset || accept;
  assign incr       = wrap;

  clock12_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk_i (clk),
    .clr_i (presc_clr),
    .tick_i(presc_tick),
    .wrap_o(wrap)
  );

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    pm_d        = pm_q;
    sec_pulse_d = 1'b0;
    set_err_d   = reject;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StApply;
          hour_d  = set_hour;
          min_d   = set_min;
          pm_d    = set_pm;
          sec_d   = '0;
        end else if (incr) begin
          sec_pulse_d = 1'b1;
          if (sec_q == SEC_MAX) begin
            sec_d = '0;
            if (min_q == MIN_MAX) begin
              min_d = '0;
              if (hour_q == HOUR_MAX) begin
                hour_d = HOUR_MIN;
              end else begin
                hour_d = hour_q + 4'd1;
                if (hour_q == HOUR_PRE_12) pm_d = ~pm_q;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      StApply: state_d = StIdle;
    endcase
    set_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= HOUR_MAX;
      pm_q        <= 1'b0;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
      set_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      sec_pulse_q <= sec_pulse_d;
      set_err_q   <= set_err_d;
      set_ready_q <= set_ready_d;
    end
  end

  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign pm        = pm_q;
  assign sec_pulse = sec_pulse_q;
  assign set_err   = set_err_q;
  assign set_ready = set_ready_q;

`ifdef ALARM_EN
  logic alarm_q, alarm_d, alarm_hit;

  // Matched against the post-increment time so loads can never fire it.
  assign alarm_hit = incr && alarm_arm && (sec_d == '0) && (hour_d == alarm_hour) &&
                     (min_d == alarm_min) && (pm_d == alarm_pm);

  always_comb begin
    alarm_d = alarm_hit || (alarm_q && !alarm_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule
